// File: rtl/reg_mem_store.sv
// Purpose: saves/restores registers x1..x31 between the register file and NUM_CTX on-chip context slots.
// Latency: BUSY for 31 cycles after request acceptance, DONE in the 32nd cycle; a bad restore signals ERROR+DONE in the next cycle.
// Backpressure: none; request edges that arrive outside IDLE are dropped, and the pipeline must not write the RF while BUSY=1.
module reg_mem_store #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CTX    = 4,
  parameter int CTX_BITS   = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  RM_write,
  input  logic                  RM_read,
  input  logic [CTX_BITS-1:0]   CTX_SEL,
  output logic [4:0]            RF_ADDR,
  input  logic [DATA_WIDTH-1:0] RF_RDATA,
  output logic [DATA_WIDTH-1:0] RF_WDATA,
  output logic                  RF_WE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_RESTORE,
    S_DONE,
    S_ERR
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_wr_q;
  logic                  r_rd_q;
  logic [4:0]            r_idx;
  logic [CTX_BITS-1:0]   r_ctx;
  logic [NUM_CTX-1:0]    r_valid;
  // x0 is never stored, so word k of a slot holds register x(k+1)
  logic [DATA_WIDTH-1:0] r_mem [NUM_CTX][31];

  logic       w_wr_rise;
  logic       w_rd_rise;
  logic       w_accept;
  logic       w_last;
  logic       w_busy;
  logic [4:0] w_word;

  assign w_wr_rise = RM_write & ~r_wr_q;
  assign w_rd_rise = RM_read & ~r_rd_q;
  assign w_accept  = (r_state == S_IDLE) && (w_wr_rise || w_rd_rise);
  assign w_last    = (r_idx == 5'd31);
  assign w_busy    = (r_state == S_SAVE) || (r_state == S_RESTORE);
  assign w_word    = r_idx - 5'd1;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and output decode; outputs depend only on state/idx (plus memory read data)
  always_comb begin
    w_state_nxt = r_state;
    BUSY        = 1'b0;
    DONE        = 1'b0;
    ERROR       = 1'b0;
    RF_WE       = 1'b0;
    RF_ADDR     = 5'd0;
    RF_WDATA    = '0;
    case (r_state)
      S_IDLE: begin
        // save wins when both requests rise on the same edge
        if (w_wr_rise) begin
          w_state_nxt = S_SAVE;
        end else if (w_rd_rise) begin
          w_state_nxt = r_valid[CTX_SEL] ? S_RESTORE : S_ERR;
        end
      end
      S_SAVE: begin
        BUSY    = 1'b1;
        RF_ADDR = r_idx;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_RESTORE: begin
        BUSY     = 1'b1;
        RF_ADDR  = r_idx;
        RF_WE    = 1'b1;
        RF_WDATA = r_mem[r_ctx][w_word];
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        DONE        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        DONE        = 1'b1;
        ERROR       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request history, slot/index bookkeeping and slot-valid flags
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_q  <= 1'b0;
      r_rd_q  <= 1'b0;
      r_idx   <= 5'd0;
      r_ctx   <= '0;
      r_valid <= '0;
    end else begin
      r_wr_q <= RM_write;
      r_rd_q <= RM_read;
      if (w_accept) begin
        r_ctx <= CTX_SEL;
        r_idx <= 5'd1;
      end else if (w_busy) begin
        r_idx <= w_last ? 5'd0 : r_idx + 5'd1;
      end
      if ((r_state == S_SAVE) && w_last) r_valid[r_ctx] <= 1'b1;
    end
  end

  // Slot storage capture during save; contents are deliberately not reset
  always_ff @(posedge CLK) begin
    if (r_state == S_SAVE) r_mem[r_ctx][w_word] <= RF_RDATA;
  end

endmodule

// File: tb/tb_reg_mem_store.sv
// Purpose: randomized self-checking bench for reg_mem_store against a slot-array reference model.
// Latency: each transfer is observed for a bounded window after the acceptance edge.
// Backpressure: n/a; the bench owns the register file model and the request lines.
module tb_reg_mem_store;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        RM_write;
  logic        RM_read;
  logic [1:0]  CTX_SEL;
  logic [4:0]  RF_ADDR;
  logic [31:0] RF_RDATA;
  logic [31:0] RF_WDATA;
  logic        RF_WE;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;

  always #5 CLK = ~CLK;

  reg_mem_store #(.DATA_WIDTH(32), .NUM_CTX(4), .CTX_BITS(2)) dut (
    .CLK(CLK), .RESET(RESET), .RM_write(RM_write), .RM_read(RM_read), .CTX_SEL(CTX_SEL),
    .RF_ADDR(RF_ADDR), .RF_RDATA(RF_RDATA), .RF_WDATA(RF_WDATA), .RF_WE(RF_WE),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  // Register file environment: async read, sync write, bulk load from the bench
  logic [31:0] rf     [32];
  logic [31:0] rf_pat [32];
  logic        ld_req;

  assign RF_RDATA = rf[RF_ADDR];

  always @(posedge CLK) begin
    if (RF_WE) rf[RF_ADDR] <= RF_WDATA;
    else if (ld_req) for (int i = 0; i < 32; i++) rf[i] <= rf_pat[i];
  end

  // Reference model: slot contents, slot validity, expected register file
  logic [31:0] ref_mem [4][32];
  bit          ref_valid [4];
  logic [31:0] rf_exp [32];

  int checks   = 0;
  int failures = 0;

  int busy_cnt, we_cnt, done_cnt, done_k, err_cnt, addr_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // mode 0: 0xA000_0000+i, mode 1: zeros, otherwise random
  task automatic load_rf(input int mode);
    for (int i = 0; i < 32; i++) begin
      if (mode == 0)      rf_pat[i] = 32'hA000_0000 + i;
      else if (mode == 1) rf_pat[i] = 32'h0;
      else                rf_pat[i] = $urandom;
    end
    rf_pat[0] = 32'h0;
    @(negedge CLK);
    ld_req = 1'b1;
    @(negedge CLK);
    ld_req = 1'b0;
    for (int i = 0; i < 32; i++) rf_exp[i] = rf_pat[i];
  endtask

  // Raise the request lines, then observe a bounded window of cycles after the acceptance edge
  task automatic xfer(input bit wr, input bit rd, input logic [1:0] ctx,
                      input int hold, input int rst_at, input int ncyc);
    busy_cnt = 0; we_cnt = 0; done_cnt = 0; done_k = 0; err_cnt = 0; addr_bad = 0;
    @(negedge CLK);
    RM_write = wr;
    RM_read  = rd;
    CTX_SEL  = ctx;
    @(posedge CLK);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge CLK);
      if (BUSY) begin
        busy_cnt++;
        if (RF_ADDR != busy_cnt[4:0]) addr_bad++;
      end
      if (RF_WE) we_cnt++;
      if (DONE) begin
        done_cnt++;
        if (done_k == 0) done_k = k;
      end
      if (ERROR) err_cnt++;
      if (k >= hold) begin
        RM_write = 1'b0;
        RM_read  = 1'b0;
      end
      CTX_SEL = 2'($urandom);
      RESET   = (rst_at != 0) && (k == rst_at);
    end
  endtask

  task automatic op(input bit wr, input bit rd, input logic [1:0] ctx,
                    input int hold, input int rst_at, input string tag);
    bit v;
    v = ref_valid[ctx];
    xfer(wr, rd, ctx, hold, rst_at, (hold > 40) ? hold + 40 : 40);
    if (rst_at != 0) begin
      chk({tag, ".busy"}, busy_cnt, rst_at);
      chk({tag, ".done"}, done_cnt, 0);
      chk({tag, ".err"}, err_cnt, 0);
      chk({tag, ".we"}, we_cnt, 0);
      for (int s = 0; s < 4; s++) ref_valid[s] = 1'b0;
    end else if (wr) begin
      chk({tag, ".busy"}, busy_cnt, 31);
      chk({tag, ".done_k"}, done_k, 32);
      chk({tag, ".done_cnt"}, done_cnt, 1);
      chk({tag, ".we"}, we_cnt, 0);
      chk({tag, ".err"}, err_cnt, 0);
      chk({tag, ".addr"}, addr_bad, 0);
      for (int i = 1; i < 32; i++) ref_mem[ctx][i] = rf_exp[i];
      ref_valid[ctx] = 1'b1;
    end else if (v) begin
      chk({tag, ".busy"}, busy_cnt, 31);
      chk({tag, ".we"}, we_cnt, 31);
      chk({tag, ".done_k"}, done_k, 32);
      chk({tag, ".done_cnt"}, done_cnt, 1);
      chk({tag, ".err"}, err_cnt, 0);
      chk({tag, ".addr"}, addr_bad, 0);
      for (int i = 1; i < 32; i++) rf_exp[i] = ref_mem[ctx][i];
    end else begin
      chk({tag, ".busy"}, busy_cnt, 0);
      chk({tag, ".we"}, we_cnt, 0);
      chk({tag, ".done_k"}, done_k, 1);
      chk({tag, ".done_cnt"}, done_cnt, 1);
      chk({tag, ".err"}, err_cnt, 1);
    end
    for (int i = 1; i < 32; i++) chk($sformatf("%s.x%0d", tag, i), rf[i], rf_exp[i]);
  endtask

  initial begin
    bit wr, rd;
    RESET = 1'b1; RM_write = 1'b0; RM_read = 1'b0; CTX_SEL = 2'd0; ld_req = 1'b0;
    for (int s = 0; s < 4; s++) ref_valid[s] = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst.busy", BUSY, 0);
    chk("rst.done", DONE, 0);
    chk("rst.error", ERROR, 0);
    chk("rst.we", RF_WE, 0);
    chk("rst.addr", RF_ADDR, 0);
    chk("rst.wdata", RF_WDATA, 0);
    RESET = 1'b0;

    load_rf(1);
    op(1'b0, 1'b1, 2'd0, 1, 0, "err_slot0");

    load_rf(0);
    op(1'b1, 1'b0, 2'd2, 1, 0, "save2");
    load_rf(1);
    op(1'b0, 1'b1, 2'd2, 1, 0, "restore2");

    load_rf(2);
    op(1'b1, 1'b0, 2'd1, 1, 0, "saveP1");
    load_rf(2);
    op(1'b1, 1'b0, 2'd3, 1, 0, "saveQ3");
    load_rf(2);
    op(1'b0, 1'b1, 2'd1, 1, 0, "restoreP1");
    op(1'b0, 1'b1, 2'd3, 1, 0, "restoreQ3");

    load_rf(2);
    op(1'b1, 1'b1, 2'd0, 82, 0, "simul_hold");

    load_rf(2);
    op(1'b1, 1'b0, 2'd0, 1, 15, "rst_mid");
    op(1'b0, 1'b1, 2'd0, 1, 0, "after_rst");
    op(1'b0, 1'b1, 2'd2, 1, 0, "after_rst2");

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0) load_rf(2);
      wr = 1'($urandom);
      rd = 1'($urandom);
      if (!wr && !rd) rd = 1'b1;
      op(wr, rd, 2'($urandom), 1, 0, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
